// File: rtl/line_memory_responder.sv
// Line-granular backing store that answers cache line fills and writebacks
// after a fixed, parameterised latency, standing in for physical memory.
module line_memory_responder #(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned INDEX_BITS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [127:0] mem_wdata,
    input  logic [1:0]   mem_byte_enable,
    output logic [127:0] mem_rdata,
    output logic         mem_resp,
    output logic         busy
);

    localparam int unsigned DEPTH = 1 << INDEX_BITS;
    localparam logic [7:0] LOAD_COUNT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            count_q, count_d;
    logic                  is_write_q, is_write_d;
    logic [INDEX_BITS-1:0] index_q, index_d;
    logic [127:0]          wdata_q, wdata_d;
    logic [127:0]          mem_rdata_q, mem_rdata_d;
    logic                  store_we;

    logic [127:0] store [DEPTH];

    // Byte enables and the offset/alias bits of the address carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{mem_byte_enable, mem_address};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        is_write_d  = is_write_q;
        index_d     = index_q;
        wdata_d     = wdata_q;
        mem_rdata_d = mem_rdata_q;
        store_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_write) begin
                    is_write_d = 1'b1;
                    index_d    = mem_address[INDEX_BITS+3:4];
                    wdata_d    = mem_wdata;
                    count_d    = LOAD_COUNT;
                    state_d    = BUSY;
                end else if (mem_read) begin
                    is_write_d = 1'b0;
                    index_d    = mem_address[INDEX_BITS+3:4];
                    count_d    = LOAD_COUNT;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (count_q == 8'd0) begin
                    state_d = RESPOND;
                    // Loaded on entry so the read data is stable for the whole response cycle.
                    if (!is_write_q) begin
                        mem_rdata_d = store[index_q];
                    end
                end else begin
                    count_d = count_q - 8'd1;
                end
            end
            RESPOND: begin
                state_d  = IDLE;
                store_we = is_write_q && !rst;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= 8'd0;
            is_write_q  <= 1'b0;
            index_q     <= '0;
            wdata_q     <= 128'h0;
            mem_rdata_q <= 128'h0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            is_write_q  <= is_write_d;
            index_q     <= index_d;
            wdata_q     <= wdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Store is deliberately untouched by reset; a reset mid-write suppresses the commit.
    always_ff @(posedge clk) begin
        if (store_we) begin
            store[index_q] <= wdata_q;
        end
    end

    assign mem_rdata = mem_rdata_q;
    assign mem_resp  = (state_q == RESPOND);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_line_memory_responder.sv
// Scoreboard bench for line_memory_responder: a LATENCY=4 and a LATENCY=1
// instance driven with directed line fills/writebacks and hand-computed results.
module tb_line_memory_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic         rd    [2];
    logic         wr    [2];
    logic [15:0]  addr  [2];
    logic [127:0] wdata [2];
    logic [1:0]   be    [2];
    logic [127:0] rdata [2];
    logic         resp  [2];
    logic         busy  [2];

    line_memory_responder #(.LATENCY(4), .INDEX_BITS(12)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (rd[0]),
        .mem_write      (wr[0]),
        .mem_address    (addr[0]),
        .mem_wdata      (wdata[0]),
        .mem_byte_enable(be[0]),
        .mem_rdata      (rdata[0]),
        .mem_resp       (resp[0]),
        .busy           (busy[0])
    );

    line_memory_responder #(.LATENCY(1), .INDEX_BITS(12)) dut_lat1 (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (rd[1]),
        .mem_write      (wr[1]),
        .mem_address    (addr[1]),
        .mem_wdata      (wdata[1]),
        .mem_byte_enable(be[1]),
        .mem_rdata      (rdata[1]),
        .mem_resp       (resp[1]),
        .busy           (busy[1])
    );

    typedef struct {
        logic [127:0] data;
        longint       due;
    } exp_t;

    typedef struct {
        string        name;
        int           inst;
        logic [127:0] got;
        logic [127:0] want;
    } chk_t;

    exp_t   sbq0 [$];
    exp_t   sbq1 [$];
    chk_t   chkq [$];
    longint cyc   = 0;
    int     total = 0;
    int     bad   = 0;

    localparam logic [127:0] DATA_D = 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF;
    localparam logic [127:0] DATA_A = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
    localparam logic [127:0] DATA_C = 128'h0C0C0C0C_11112222_33334444_55556666;
    localparam logic [127:0] DATA_E = 128'h00000000_00000000_00000000_CAFEF00D;
    localparam logic [127:0] DATA_F = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;

    // Posedge count; a request driven at cycle N is sampled at edge N+1.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void pushChk(input string n, input int inst,
                                    input logic [127:0] g, input logic [127:0] w);
        chk_t c;
        c.name = n;
        c.inst = inst;
        c.got  = g;
        c.want = w;
        chkq.push_back(c);
    endfunction

    // Pops the oldest expectation of an instance when it pulses mem_resp.
    task automatic checkOutput(input int inst, input logic [127:0] got_data);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (inst == 0 && sbq0.size() > 0) begin
            e    = sbq0.pop_front();
            have = 1'b1;
        end else if (inst == 1 && sbq1.size() > 0) begin
            e    = sbq1.pop_front();
            have = 1'b1;
        end
        total++;
        if (!have) begin
            bad++;
            $display("[TB] FAIL unexpected_resp inst%0d: got mem_resp at cycle %0d, required none",
                     inst, cyc);
        end else begin
            if (cyc != e.due) begin
                bad++;
                $display("[TB] FAIL resp_cycle inst%0d: got %0d required %0d", inst, cyc, e.due);
            end
            total++;
            if (got_data !== e.data) begin
                bad++;
                $display("[TB] FAIL resp_rdata inst%0d: got %h required %h", inst, got_data, e.data);
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        chk_t c;
        if (resp[0] === 1'b1) checkOutput(0, rdata[0]);
        if (resp[1] === 1'b1) checkOutput(1, rdata[1]);
        while (chkq.size() > 0) begin
            c = chkq.pop_front();
            total++;
            if (c.got !== c.want) begin
                bad++;
                $display("[TB] FAIL %s inst%0d: got %h required %h", c.name, c.inst, c.got, c.want);
            end
        end
    end

    // Issues one request from an IDLE cycle and returns in the first IDLE cycle after it.
    task automatic applyStimulus(input int inst, input bit do_rd, input bit do_wr,
                                 input logic [15:0] a, input logic [127:0] d,
                                 input logic [127:0] exp_rdata, input bit hold,
                                 input bit scramble);
        exp_t e;
        int   busy_cnt;
        bit   seen;
        int   lat;
        busy_cnt = 0;
        seen     = 1'b0;
        lat      = (inst == 0) ? 4 : 1;
        rd[inst]    = do_rd;
        wr[inst]    = do_wr;
        addr[inst]  = a;
        wdata[inst] = d;
        e.data = exp_rdata;
        e.due  = cyc + 1 + lat;
        if (inst == 0) sbq0.push_back(e);
        else           sbq1.push_back(e);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (busy[inst]) busy_cnt++;
            if (scramble && k == 0) begin
                addr[inst]  = 16'hFFF0;
                wdata[inst] = '1;
            end
            if (resp[inst]) seen = 1'b1;
        end
        if (!seen) pushChk("resp_timeout", inst, 128'h0, 128'h1);
        if (hold) @(negedge clk);
        rd[inst] = 1'b0;
        wr[inst] = 1'b0;
        if (!hold) @(negedge clk);
        pushChk("busy_cycles", inst, 128'(busy_cnt), 128'(lat + 1));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rd[i]    = 1'b0;
            wr[i]    = 1'b0;
            addr[i]  = 16'h0;
            wdata[i] = 128'h0;
            be[i]    = 2'b11;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            pushChk("reset_busy",  i, 128'(busy[i]), 128'h0);
            pushChk("reset_resp",  i, 128'(resp[i]), 128'h0);
            pushChk("reset_rdata", i, rdata[i],      128'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] latency-4 instance: write, aliased read, unwritten read");
        applyStimulus(0, 1'b0, 1'b1, 16'h1230, DATA_D, 128'h0,  1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 16'h1238, 128'h0, DATA_D,  1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 16'h4560, 128'h0, 128'h0,  1'b0, 1'b0);

        $display("[TB] simultaneous read and write");
        applyStimulus(0, 1'b1, 1'b1, 16'h0100, 128'h1, 128'h0,  1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 16'h0100, 128'h0, 128'h1,  1'b0, 1'b0);

        $display("[TB] reset during an in-flight write");
        wr[0]    = 1'b1;
        addr[0]  = 16'h0200;
        wdata[0] = DATA_A;
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
        wr[0] = 1'b0;
        @(negedge clk);
        pushChk("midrst_busy",  0, 128'(busy[0]), 128'h0);
        pushChk("midrst_resp",  0, 128'(resp[0]), 128'h0);
        pushChk("midrst_rdata", 0, rdata[0],      128'h0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0, 16'h0200, 128'h0, 128'h0,  1'b0, 1'b0);

        $display("[TB] held request and back-to-back read");
        applyStimulus(0, 1'b1, 1'b0, 16'h1230, 128'h0, DATA_D,  1'b1, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 16'h0100, 128'h0, 128'h1,  1'b0, 1'b0);

        $display("[TB] address and data changed while busy");
        applyStimulus(0, 1'b0, 1'b1, 16'h0400, DATA_C, 128'h1,  1'b0, 1'b1);
        applyStimulus(0, 1'b1, 1'b0, 16'h0400, 128'h0, DATA_C,  1'b0, 1'b0);
        applyStimulus(0, 1'b1, 1'b0, 16'hFFF0, 128'h0, 128'h0,  1'b0, 1'b0);

        $display("[TB] latency-1 instance");
        applyStimulus(1, 1'b1, 1'b0, 16'h0010, 128'h0, 128'h0,  1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b1, 16'h0020, DATA_E, 128'h0,  1'b0, 1'b1);
        applyStimulus(1, 1'b1, 1'b0, 16'h0020, 128'h0, DATA_E,  1'b0, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 16'hFFF0, 128'h0, 128'h0,  1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b1, 16'h0030, DATA_F, 128'h0,  1'b1, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 16'h0030, 128'h0, DATA_F,  1'b0, 1'b0);

        repeat (5) @(negedge clk);
        pushChk("sb_leftover", 0, 128'(sbq0.size()), 128'h0);
        pushChk("sb_leftover", 1, 128'(sbq1.size()), 128'h0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
